// File: rtl/fb_pkg.sv
// Shared types and constants for the 2-bpp frame buffer scanout path.
package fb_pkg;

    localparam int FB_AW = 13;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        BLANK,
        ACTIVE
    } state_t;

    // Entry 0 of every palette is never shown: index 0 always resolves to the background.
    localparam rgb_t PALETTE [4][4] = '{
        '{24'h000000, 24'h555555, 24'hAAAAAA, 24'hFFFFFF},
        '{24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF},
        '{24'h000000, 24'h00FFFF, 24'hFF00FF, 24'hFFFF00},
        '{24'h000000, 24'h804000, 24'h408000, 24'h004080}
    };

endpackage

// File: rtl/fb_palette_lut.sv
// Stage-2 colour resolve: frame buffer index -> registered 24-bit RGB.
// Optional half-intensity grid overlay when FB_SCANOUT_GRID_EN is defined.
module fb_palette_lut
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic        in_img,
    input  logic [1:0]  index,
    input  logic [1:0]  pal,
    input  logic [23:0] bgcolour,
`ifdef FB_SCANOUT_GRID_EN
    input  logic        grid,
`endif
    output logic [23:0] rgb
);

`ifdef FB_SCANOUT_GRID_EN
    function automatic rgb_t half_rgb(input rgb_t c);
        return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
    endfunction
`endif

    rgb_t colour;

    always_comb begin
        colour = bgcolour;
        if (in_img && index != 2'd0)
            colour = PALETTE[pal][index];
`ifdef FB_SCANOUT_GRID_EN
        if (in_img && grid)
            colour = half_rgb(colour);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rgb <= '0;
        else
            rgb <= vld ? colour : '0;
    end

endmodule

// File: rtl/fb_scanout.sv
// Frame buffer scanout: timing strobes -> read address -> palette RGB, 3-cycle latency.
// Optional pixel grid overlay is built when FB_SCANOUT_GRID_EN is defined.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int IMG_W      = 80,
    parameter int IMG_H      = 60,
    parameter int SCALE_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [1:0]  palette,
    input  logic [23:0] bgcolour,
    input  logic [1:0]  fb_data,
    output logic [12:0] fb_addr,
    output logic [23:0] rgb,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out
);

    localparam int                CW        = 11;
    localparam logic [CW-1:0]     CNT_MAX   = '1;
    localparam logic [CW-1:0]     IMG_W_C   = CW'(IMG_W);
    localparam logic [CW-1:0]     IMG_H_C   = CW'(IMG_H);
    localparam logic [FB_AW-1:0]  LINE_STEP = FB_AW'(IMG_W);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    state_t           state;
    logic [CW-1:0]    sx, sy;
    logic [FB_AW-1:0] line_base;
    logic             de_prev, vs_prev;
    logic [1:0]       pal_lat;
    logic [23:0]      bg_lat;

    logic             vs_rise, de_rise, de_fall, pix, in_img, row_adv;
    logic [CW-1:0]    img_x, img_y, sy_inc;

    logic             vld_p0, vld_p1;
    logic             in_img_p0, in_img_p1;
    logic             de_p0, de_p1, de_p2;
    logic             hs_p0, hs_p1, hs_p2;
    logic             vs_p0, vs_p1, vs_p2;
`ifdef FB_SCANOUT_GRID_EN
    logic             grid_p0, grid_p1;
`endif

    // A pixel is live on every ACTIVE cycle and on the DE rising cycle itself, so the
    // first column of a line gets sx = 0 and stays aligned with the delayed strobes.
    always_comb begin
        vs_rise = vs_in & ~vs_prev;
        de_rise = de_in & ~de_prev;
        de_fall = ~de_in & de_prev;
        pix     = de_in & ~vs_rise & ((state == ACTIVE) | ((state == BLANK) & de_rise));
        img_x   = sx >> SCALE_LOG2;
        img_y   = sy >> SCALE_LOG2;
        in_img  = (img_x < IMG_W_C) && (img_y < IMG_H_C);
        sy_inc  = sat_inc(sy);
        row_adv = (sy_inc != sy) && (sy_inc[SCALE_LOG2-1:0] == '0) &&
                  ((sy_inc >> SCALE_LOG2) < IMG_H_C);
    end

    // Stage 0: FSM, counters, line base and the registered read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_FRAME;
            sx        <= '0;
            sy        <= '0;
            line_base <= '0;
            de_prev   <= 1'b0;
            vs_prev   <= 1'b0;
            fb_addr   <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            {de_p0, de_p1, de_p2} <= '0;
            {hs_p0, hs_p1, hs_p2} <= '0;
            {vs_p0, vs_p1, vs_p2} <= '0;
        end else begin
            de_prev <= de_in;
            vs_prev <= vs_in;
            {de_p0, de_p1, de_p2} <= {de_in, de_p0, de_p1};
            {hs_p0, hs_p1, hs_p2} <= {hs_in, hs_p0, hs_p1};
            {vs_p0, vs_p1, vs_p2} <= {vs_in, vs_p0, vs_p1};
            vld_p0 <= pix;
            vld_p1 <= vld_p0;
            if (pix && in_img)
                fb_addr <= line_base + FB_AW'(img_x);
            if (vs_rise) begin
                state     <= BLANK;
                sx        <= '0;
                sy        <= '0;
                line_base <= '0;
            end else begin
                case (state)
                    BLANK:   if (de_rise) state <= ACTIVE;
                    ACTIVE:  if (de_fall) state <= BLANK;
                    default: ;
                endcase
                if (pix)
                    sx <= sat_inc(sx);
                if (de_fall && state == ACTIVE) begin
                    sx <= '0;
                    sy <= sy_inc;
                    if (row_adv)
                        line_base <= line_base + LINE_STEP;
                end
            end
        end
    end

    // Stage 1: frame buffer read in flight; carry pixel attributes alongside it.
    always_ff @(posedge clk) begin
        in_img_p0 <= in_img;
        in_img_p1 <= in_img_p0;
        if (vs_rise) begin
            pal_lat <= palette;
            bg_lat  <= bgcolour;
        end
`ifdef FB_SCANOUT_GRID_EN
        grid_p0 <= (sx[SCALE_LOG2-1:0] == '0) || (sy[SCALE_LOG2-1:0] == '0);
        grid_p1 <= grid_p0;
`endif
    end

    // Stage 2: registered colour resolve.
    fb_palette_lut u_lut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld      (vld_p1),
        .in_img   (in_img_p1),
        .index    (fb_data),
        .pal      (pal_lat),
        .bgcolour (bg_lat),
`ifdef FB_SCANOUT_GRID_EN
        .grid     (grid_p1),
`endif
        .rgb      (rgb)
    );

    assign de_out = de_p2;
    assign hs_out = hs_p2;
    assign vs_out = vs_p2;

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: randomized frames against a pixel-coordinate reference model.
module tb_fb_scanout;

    logic        clk, rst_n, de_in, hs_in, vs_in;
    logic [1:0]  palette;
    logic [23:0] bgcolour;
    logic [1:0]  fb_data;
    logic [12:0] fb_addr;
    logic [23:0] rgb;
    logic        de_out, hs_out, vs_out;

    fb_scanout dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .de_in    (de_in),
        .hs_in    (hs_in),
        .vs_in    (vs_in),
        .palette  (palette),
        .bgcolour (bgcolour),
        .fb_data  (fb_data),
        .fb_addr  (fb_addr),
        .rgb      (rgb),
        .de_out   (de_out),
        .hs_out   (hs_out),
        .vs_out   (vs_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered frame buffer RAM: data appears one cycle after the address.
    logic [1:0] mem [0:8191];
    always @(posedge clk) fb_data <= mem[fb_addr];

    localparam logic [23:0] REF_PAL [4][4] = '{
        '{24'h000000, 24'h555555, 24'hAAAAAA, 24'hFFFFFF},
        '{24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF},
        '{24'h000000, 24'h00FFFF, 24'hFF00FF, 24'hFFFF00},
        '{24'h000000, 24'h804000, 24'h408000, 24'h004080}
    };

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_rgb_q [$];
    logic [2:0]  strobe_q  [$];
    bit          mon_on = 1'b0;

    // Reference model state: screen coordinates since the last VSYNC.
    bit          live = 1'b0;
    int          m_sx = 0, m_sy = 0;
    logic [1:0]  m_pal = 2'd0;
    logic [23:0] m_bg = 24'd0;
    bit          prev_de = 1'b0, prev_vs = 1'b0;
    int          exp_addr = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [23:0] model_pixel(input int xs, input int ys);
        int          x = xs / 8;
        int          y = ys / 8;
        int          idx;
        logic [23:0] c;
        if (x >= 80 || y >= 60) return m_bg;
        idx = int'(mem[y * 80 + x]);
        c = (idx == 0) ? m_bg : REF_PAL[m_pal][idx];
`ifdef FB_SCANOUT_GRID_EN
        if ((xs % 8) == 0 || (ys % 8) == 0)
            c = {8'(c[23:16] / 2), 8'(c[15:8] / 2), 8'(c[7:0] / 2)};
`endif
        return c;
    endfunction

    task automatic step(input bit de, input bit hs, input bit vs);
        bit vs_rise;
        @(negedge clk);
        check("fb_addr", 32'(fb_addr), 32'(exp_addr));
        de_in = de;
        hs_in = hs;
        vs_in = vs;
        vs_rise = vs && !prev_vs;
        if (vs_rise) begin
            live  = 1'b1;
            m_sx  = 0;
            m_sy  = 0;
            m_pal = palette;
            m_bg  = bgcolour;
        end
        if (de) begin
            if (live && !vs_rise) begin
                exp_rgb_q.push_back(model_pixel(m_sx, m_sy));
                if (m_sx / 8 < 80 && m_sy / 8 < 60)
                    exp_addr = (m_sy / 8) * 80 + m_sx / 8;
                m_sx++;
            end else begin
                exp_rgb_q.push_back(24'd0);
            end
        end else if (prev_de && live && !vs_rise) begin
            m_sx = 0;
            m_sy++;
        end
        strobe_q.push_back({de, hs, vs});
        prev_de = de;
        prev_vs = vs;
    endtask

    task automatic line(input int width);
        for (int i = 0; i < width; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, (i >= 2 && i < 5), 1'b0);
    endtask

    task automatic vsync();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, (i >= 2 && i < 5));
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        strobe_q.push_back(3'b000);
    endtask

    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_rgb", 32'(rgb), 32'd0);
        check("reset_fb_addr", 32'(fb_addr), 32'd0);
        check("reset_strobes", {29'd0, de_out, hs_out, vs_out}, 32'd0);
        strobe_q.delete();
        exp_rgb_q.delete();
        live     = 1'b0;
        exp_addr = 0;
        prev_de  = 1'b0;
        prev_vs  = 1'b0;
        de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        repeat (3) @(negedge clk);
        release_reset();
    endtask

    task automatic frame(input int rows, input int chg_row, input logic [1:0] chg_pal,
                         input int rst_row);
        vsync();
        for (int r = 0; r < rows; r++) begin
            int w;
            w = (r == 0 || r == 8 || r == 479) ? 800 : int'($urandom_range(8, 48));
            if (r == chg_row) begin
                palette  = chg_pal;
                bgcolour = 24'($urandom);
            end
            if (r == rst_row) begin
                for (int i = 0; i < w / 2; i++) step(1'b1, 1'b0, 1'b0);
                reset_pulse();
                return;
            end
            line(w);
        end
    endtask

    // Monitor: strobes are popped in lockstep, pixels whenever de_out presents one.
    initial begin
        logic [2:0] s;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                if (strobe_q.size() >= 3) begin
                    s = strobe_q.pop_front();
                    check("strobes", {29'd0, de_out, hs_out, vs_out}, {29'd0, s});
                end
                if (de_out) begin
                    if (exp_rgb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rgb_underflow: got de_out=1 rgb=%06h expected no pixel", rgb);
                    end else begin
                        check("rgb", 32'(rgb), 32'(exp_rgb_q.pop_front()));
                    end
                end else begin
                    check("rgb_blank", 32'(rgb), 32'd0);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 2'($urandom);
        for (int i = 0; i < 80; i++) mem[i] = 2'd2;
        de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        palette  = 2'd0;
        bgcolour = 24'($urandom);
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        mon_on = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rgb", 32'(rgb), 32'd0);
        check("reset_fb_addr", 32'(fb_addr), 32'd0);
        check("reset_strobes", {29'd0, de_out, hs_out, vs_out}, 32'd0);
        release_reset();

        for (int i = 0; i < 3; i++) line(20);
        frame(482, 200, 2'd1, -1);
        frame(24, 12, 2'd2, -1);
        frame(20, -1, 2'd0, 10);
        for (int i = 0; i < 2; i++) line(30);
        palette = 2'($urandom);
        frame(12, -1, 2'd0, -1);
        repeat (6) step(1'b0, 1'b0, 1'b0);

        check("rgb_queue_drained", 32'(exp_rgb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
